// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Shared FIFO mode constants and pointer sizing helper
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // One extra MSB distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - FIFO storage: one synchronous write port, one asynchronous read port
module fifo_dpram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - Synchronous FIFO with registered or first-word-fall-through read
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int FWFT     = FWFT_OFF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [WIDTH-1:0]          w_data,
  input  logic                      read_en,
  input  logic                      clr_err,
  output logic signed [WIDTH-1:0]   r_data,
  output logic                      r_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] head_data;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_acc = read_en && !empty;
  // A full FIFO still takes a write when a pop frees the slot in the same cycle.
  assign wr_acc = write_en && (!full || rd_acc);

  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= PW'(AF_LEVEL));
  assign almost_empty = (count <= PW'(AE_LEVEL));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    ovf_d    = (write_en && !wr_acc) || (ovf_q && !clr_err);
    udf_d    = (read_en && !rd_acc) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;

  fifo_dpram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head_data)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head is forced to zero while empty so reset and idle outputs are defined.
    assign r_data  = empty ? '0 : $signed(head_data);
    assign r_valid = !empty;
  end else begin : g_reg
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic             r_valid_q;

    always_comb begin
      r_data_d = rd_acc ? head_data : r_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= rd_acc;
      end
    end

    assign r_data  = $signed(r_data_q);
    assign r_valid = r_valid_q;
  end

endmodule
